// File: rtl/hazard_scoreboard.sv
// Purpose : ID-stage register-dependency decode plus an in-flight destination
//           scoreboard that yields the load-use stall and per-source forwarding
//           selects, with flush, global hold and a saturating stall counter.
// Latency : decode, stall_o and fwd*_sel are combinational from id_instr and the
//           current scoreboard; the ID instruction enters stage 1 on the next
//           non-held rising edge.
// Backpressure: stall_o requests the ID stage to hold its instruction while a
//           bubble is inserted; hold freezes the scoreboard and the counter.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid, id_instr  instruction currently in ID
//   flush, hold         kill the ID instruction / freeze everything
//   rs1_o, rs2_o, rd_o  decoded register numbers (0 when the field is unused)
//   stall_o             load-use stall request
//   fwd1_sel, fwd2_sel  forwarding source per operand: 0 = regfile, k = stage k
//   stall_cnt           saturating number of non-held stall cycles
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SW      = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             flush,
  input  logic             hold,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic             stall_o,
  output logic [SW-1:0]    fwd1_sel,
  output logic [SW-1:0]    fwd2_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [6:0] opcode;
  logic       is_load;
  logic       live;

  // Scoreboard entries, index 1 = EX (youngest), index STAGES = oldest.
  logic [STAGES:1] ent_v;
  logic [STAGES:1] ent_ld;
  logic [4:0]      ent_rd [1:STAGES];

  logic          hz1, hz2;
  logic [SW-1:0] sel1, sel2;
  logic          accept;

  // Opcode/funct bits that the scoreboard does not need.
  logic unused_bits;
  assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

  assign opcode  = id_instr[6:0];
  assign is_load = (opcode == 7'b0000011);
  assign live    = id_valid && !flush;

  // Register-field decode by instruction format.
  always_comb begin
    rd_o  = '0;
    rs1_o = '0;
    rs2_o = '0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: begin   // LUI, AUIPC, JAL
        rd_o = id_instr[11:7];
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin   // JALR, loads, OP-IMM
        rd_o  = id_instr[11:7];
        rs1_o = id_instr[19:15];
      end
      7'b0110011: begin                           // OP
        rd_o  = id_instr[11:7];
        rs1_o = id_instr[19:15];
        rs2_o = id_instr[24:20];
      end
      7'b1100011, 7'b0100011: begin               // branches, stores
        rs1_o = id_instr[19:15];
        rs2_o = id_instr[24:20];
      end
      default: ;
    endcase
  end

  // Walk from the oldest stage to the youngest so the youngest match is the
  // last one written and therefore decides. A load that is still too young to
  // have its data is a hazard rather than a forwarding source.
  always_comb begin
    hz1  = 1'b0;
    hz2  = 1'b0;
    sel1 = '0;
    sel2 = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (ent_v[k] && ent_rd[k] == rs1_o && rs1_o != 5'd0) begin
        if (ent_ld[k] && k <= LOAD_LAT) begin
          hz1  = 1'b1;
          sel1 = '0;
        end else begin
          hz1  = 1'b0;
          sel1 = SW'(k);
        end
      end
      if (ent_v[k] && ent_rd[k] == rs2_o && rs2_o != 5'd0) begin
        if (ent_ld[k] && k <= LOAD_LAT) begin
          hz2  = 1'b1;
          sel2 = '0;
        end else begin
          hz2  = 1'b0;
          sel2 = SW'(k);
        end
      end
    end
  end

  assign stall_o  = live && (hz1 || hz2);
  assign fwd1_sel = live ? sel1 : '0;
  assign fwd2_sel = live ? sel2 : '0;
  // Flushed, invalid or stalled instructions become a bubble in stage 1.
  assign accept   = live && !stall_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v     <= '0;
      ent_ld    <= '0;
      stall_cnt <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        ent_rd[k] <= '0;
      end
    end else if (!hold) begin
      for (int k = STAGES; k >= 2; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_ld[k] <= ent_ld[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
      ent_v[1]  <= accept;
      ent_ld[1] <= accept && is_load;
      ent_rd[1] <= accept ? rd_o : 5'd0;
      if (stall_o && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, flush, hold;
  logic [31:0] id_instr;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        stall_o;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [15:0] stall_cnt;

  // Second instance: deep load latency and a 2-bit counter for saturation.
  logic        s_valid, s_flush, s_hold;
  logic [31:0] s_instr;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_stall;
  logic [2:0]  s_f1, s_f2;
  logic [1:0]  s_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .flush(flush), .hold(hold), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .stall_o(stall_o), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.STAGES(6), .LOAD_LAT(5), .CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .id_valid(s_valid), .id_instr(s_instr),
    .flush(s_flush), .hold(s_hold), .rs1_o(s_rs1), .rs2_o(s_rs2), .rd_o(s_rd),
    .stall_o(s_stall), .fwd1_sel(s_f1), .fwd2_sel(s_f2), .stall_cnt(s_cnt)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        flush;
    logic        hold;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic v, logic [31:0] in, logic fl, logic ho,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                              logic st, logic [1:0] f1, logic [1:0] f2,
                              logic [15:0] cnt);
    vec_t t;
    t.valid = v;  t.instr = in; t.flush = fl; t.hold = ho;
    t.rs1 = r1;   t.rs2 = r2;   t.rd = rd;    t.stall = st;
    t.f1 = f1;    t.f2 = f2;    t.cnt = cnt;
    return t;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] in, input logic fl,
                       input logic ho);
    id_valid = v;
    id_instr = in;
    flush    = fl;
    hold     = ho;
    #2;
  endtask

  // Instruction encodings
  localparam logic [31:0] ADD_5_1_2  = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] ADD_6_5_5  = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] LW_5_1     = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] ADD_6_5_0  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] ADD_4_3_0  = 32'h00018233; // add x4,x3,x0
  localparam logic [31:0] ADDI_3_1   = 32'h00100193; // addi x3,x0,1
  localparam logic [31:0] ADDI_3_2   = 32'h00200193; // addi x3,x0,2
  localparam logic [31:0] NOP        = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] ADD_1_0_0  = 32'h000000B3; // add x1,x0,x0
  localparam logic [31:0] SW_5_4_6   = 32'h00532223; // sw  x5,4(x6)
  localparam logic [31:0] ADD_7_4_0  = 32'h000203B3; // add x7,x4,x0
  localparam logic [31:0] LUI_7      = 32'h123453B7; // lui x7,0x12345
  localparam logic [31:0] BEQ_1_2    = 32'h00208463; // beq x1,x2,8
  localparam logic [31:0] ADD_7_6_6  = 32'h006303B3; // add x7,x6,x6

  initial begin
    //              v  instr      fl ho  rs1 rs2 rd  st f1 f2 cnt
    vecs[0]  = mk(0, ADD_5_1_2, 0, 0,  1,  2,  5, 0, 0, 0, 0);
    vecs[1]  = mk(1, ADD_5_1_2, 0, 0,  1,  2,  5, 0, 0, 0, 0);
    vecs[2]  = mk(1, ADD_6_5_5, 0, 0,  5,  5,  6, 0, 1, 1, 0);
    vecs[3]  = mk(1, ADD_6_5_5, 0, 0,  5,  5,  6, 0, 2, 2, 0);
    vecs[4]  = mk(1, LW_5_1,    0, 0,  1,  0,  5, 0, 0, 0, 0);
    vecs[5]  = mk(1, ADD_6_5_0, 0, 0,  5,  0,  6, 1, 0, 0, 0);
    vecs[6]  = mk(1, ADD_6_5_0, 0, 0,  5,  0,  6, 0, 2, 0, 1);
    vecs[7]  = mk(1, ADD_4_3_0, 0, 0,  3,  0,  4, 0, 0, 0, 1);
    vecs[8]  = mk(1, ADDI_3_1,  0, 0,  0,  0,  3, 0, 0, 0, 1);
    vecs[9]  = mk(1, ADDI_3_2,  0, 0,  0,  0,  3, 0, 0, 0, 1);
    vecs[10] = mk(1, ADD_4_3_0, 0, 0,  3,  0,  4, 0, 1, 0, 1);
    vecs[11] = mk(1, NOP,       0, 0,  0,  0,  0, 0, 0, 0, 1);
    vecs[12] = mk(1, ADD_1_0_0, 0, 0,  0,  0,  1, 0, 0, 0, 1);
    vecs[13] = mk(1, ADD_5_1_2, 0, 0,  1,  2,  5, 0, 1, 0, 1);
    vecs[14] = mk(1, SW_5_4_6,  0, 0,  6,  5,  0, 0, 0, 1, 1);
    vecs[15] = mk(1, ADD_7_4_0, 0, 0,  4,  0,  7, 0, 0, 0, 1);
    vecs[16] = mk(1, LUI_7,     0, 0,  0,  0,  7, 0, 0, 0, 1);
    vecs[17] = mk(1, BEQ_1_2,   0, 0,  1,  2,  0, 0, 0, 0, 1);
    vecs[18] = mk(1, LW_5_1,    0, 0,  1,  0,  5, 0, 0, 0, 1);
    vecs[19] = mk(1, ADD_6_5_0, 1, 0,  5,  0,  6, 0, 0, 0, 1);
    vecs[20] = mk(1, ADD_6_5_0, 0, 0,  5,  0,  6, 0, 2, 0, 1);
    vecs[21] = mk(1, ADD_6_5_0, 0, 0,  5,  0,  6, 0, 3, 0, 1);
    vecs[22] = mk(0, ADD_7_6_6, 0, 0,  6,  6,  7, 0, 0, 0, 1);
    vecs[23] = mk(1, ADD_7_6_6, 0, 0,  6,  6,  7, 0, 2, 2, 1);

    rst_n = 1'b0;
    s_valid = 1'b0; s_instr = 32'h0; s_flush = 1'b0; s_hold = 1'b0;
    drive(1, ADD_6_5_5, 0, 0);
    // Reset state: empty scoreboard never stalls or forwards.
    check("reset stall", stall_o, 0);
    check("reset fwd1", fwd1_sel, 0);
    check("reset fwd2", fwd2_sel, 0);
    check("reset cnt", stall_cnt, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].valid, vecs[i].instr, vecs[i].flush, vecs[i].hold);
      check($sformatf("v%0d rs1", i),   rs1_o,     vecs[i].rs1);
      check($sformatf("v%0d rs2", i),   rs2_o,     vecs[i].rs2);
      check($sformatf("v%0d rd", i),    rd_o,      vecs[i].rd);
      check($sformatf("v%0d stall", i), stall_o,   vecs[i].stall);
      check($sformatf("v%0d fwd1", i),  fwd1_sel,  vecs[i].f1);
      check($sformatf("v%0d fwd2", i),  fwd2_sel,  vecs[i].f2);
      check($sformatf("v%0d cnt", i),   stall_cnt, vecs[i].cnt);
      step();
    end

    // Hold for three edges during a load-use stall.
    drive(1, LW_5_1, 0, 0);
    check("hold lw stall", stall_o, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, ADD_6_5_0, 0, 1);
      check($sformatf("hold%0d stall", i), stall_o, 1);
      check($sformatf("hold%0d cnt", i), stall_cnt, 1);
      step();
    end
    drive(1, ADD_6_5_0, 0, 0);
    check("hold release stall", stall_o, 1);
    check("hold release cnt", stall_cnt, 1);
    step();
    drive(1, ADD_6_5_0, 0, 0);
    check("post stall stall", stall_o, 0);
    check("post stall fwd1", fwd1_sel, 2);
    check("post stall cnt", stall_cnt, 2);
    step();
    drive(1, ADD_6_5_0, 0, 0);
    check("pre reset fwd1", fwd1_sel, 3);

    // Asynchronous reset between edges clears state at once.
    rst_n = 1'b0;
    #1;
    check("async rst stall", stall_o, 0);
    check("async rst fwd1", fwd1_sel, 0);
    check("async rst cnt", stall_cnt, 0);
    step();
    rst_n = 1'b1;
    drive(1, ADD_6_5_0, 0, 0);
    check("after rst fwd1", fwd1_sel, 0);
    check("after rst cnt", stall_cnt, 0);
    drive(0, NOP, 0, 0);
    step();

    // Saturation: a load tracked as a hazard through stages 1..5 stalls for
    // five consecutive cycles; the 2-bit counter stops at 3.
    s_valid = 1'b1;
    s_instr = LW_5_1;
    #2;
    check("sat lw stall", s_stall, 0);
    step();
    s_instr = ADD_6_5_0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("sat%0d stall", i), s_stall, 1);
      check($sformatf("sat%0d cnt", i), s_cnt, (i < 3) ? i : 3);
      step();
    end
    #2;
    check("sat end stall", s_stall, 0);
    check("sat end fwd1", s_f1, 6);
    check("sat end cnt", s_cnt, 3);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage register-dependency decode.
- Decodes the source and destination registers of the instruction in ID, and tracks destinations of in-flight instructions across STAGES pipeline stages (EX onward).
- Generates the load-use stall and a per-source forwarding select, with flush, global hold and a saturating stall-cycle counter.
- Sits between the ID stage and the ID/EX pipeline register.

Parameters:
- STAGES, 3, number of tracked in-flight stages; stage 1 = EX, stage STAGES = oldest.
- LOAD_LAT, 1, a load's result is forwardable only from stage index > LOAD_LAT; range 1..STAGES-1.
- CNT_W, 16, stall counter width.
- SW, $clog2(STAGES+1), forwarding-select width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  id_instr holds a real instruction.
- id_instr  in  32  RV32I instruction in ID.
- flush  in  1  kill the ID instruction (branch redirect).
- hold  in  1  global freeze (e.g. memory wait).
- rs1_o  out  5  decoded rs1, or 0 if unused.
- rs2_o  out  5  decoded rs2, or 0 if unused.
- rd_o  out  5  decoded rd, or 0 if no write.
- stall_o  out  1  load-use stall request.
- fwd1_sel  out  SW  rs1 forwarding source: 0 = register file, k = stage k.
- fwd2_sel  out  SW  rs2 forwarding source, same encoding.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Decode (combinational), opcode = id_instr[6:0]:
  - rd = [11:7] for 0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011; else 0.
  - rs1 = [19:15] for 1100111, 1100011, 0000011, 0100011, 0010011, 0110011; else 0.
  - rs2 = [24:20] for 1100011, 0100011, 0110011; else 0.
  - is_load = (opcode == 0000011).
- State: STAGES entries, each {v, rd[4:0], ld}. Reset clears all v, all rd, all ld, and stall_cnt to 0.
- match(s,k) = v[k] && rd[k] == s && s != 0. Register x0 never matches.
- Hazard, per source s: the youngest matching stage k (lowest index) decides.
  - If ld[k] and k <= LOAD_LAT: hazard.
  - Otherwise fwdN_sel = k.
  - No match: fwdN_sel = 0.
  - An older match is never selected when a younger one exists.
- stall_o = id_valid && !flush && (hazard on rs1 || hazard on rs2).
- fwd*_sel are forced to 0 when !id_valid or flush.
- Rising edge with hold = 0:
  - Entries shift: stage k+1 <= stage k.
  - Stage 1 <= {1, rd, is_load} if id_valid && !flush && !stall_o; otherwise a bubble (v = 0).
  - The oldest entry retires.
- Rising edge with hold = 1: all entries and stall_cnt hold. The combinational outputs still reflect the current state.
- stall_cnt increments when stall_o && !hold, and saturates at all-ones.
- Flush and stall in the same cycle: flush wins; stall_o = 0 and a bubble is inserted.
- rst_n asserted mid-operation: state clears immediately, without waiting for a clock edge. With no valid entries, stall_o = 0 and fwd*_sel = 0 regardless of id_instr.
- Latency:
  - The decode, stall and forwarding outputs are combinational from id_instr and current state.
  - An instruction accepted at edge N is visible as stage 1 from edge N onward, and as stage k after k-1 further non-held edges.

Test Plan:
- Reset: after several accepted instructions, pulse rst_n low between edges -> stall_o = 0, fwd*_sel = 0, stall_cnt = 0 immediately.
- Forwarding chain: add x5,x1,x2 (0x002082B3), then add x6,x5,x5 (0x00528333) -> fwd1_sel = fwd2_sel = 1, stall_o = 0. With the same consumer held in ID two edges after the producer -> fwd*_sel = 2.
- Load-use: lw x5,0(x1) (0x0000A283), then add x6,x5,x0 -> stall_o = 1 for exactly one cycle and a bubble enters. The next cycle gives fwd1_sel = 2, stall_o = 0, stall_cnt = 1.
- Youngest wins and x0 rules:
  - addi x3 twice, then add x4,x3,x0 -> fwd1_sel = 1.
  - addi x0, then add x1,x0,x0 -> both selects 0.
  - add x5, then sw x5,0(x6) -> fwd2_sel = 1, with no write tracked for the store.
- Flush and hold:
  - lw x5 in stage 1 with a dependent instruction and flush = 1 -> stall_o = 0, and the bubble is inserted.
  - hold = 1 for 3 cycles during a load-use stall -> entries unchanged, stall_cnt unchanged.
- Saturation: CNT_W = 2, force 5 consecutive stall cycles -> stall_cnt = 3.
